serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial add sequencer. Time-shares one full_adder cell across all bits of a
//   WIDTH-bit addition, LSB first, one bit per clock, with the carry held in a flop.
//   Sits between a start/done requester and the single-bit full_adder datapath.
//   Trades latency (WIDTH cycles) for area.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//   clk     in   1      single clock, all state updates on rising edge
//   rst_n   in   1      synchronous, active-low reset
//   start   in   1      request; sampled only when busy==0
//   a       in   WIDTH  operand A, captured on accepted start
//   b       in   WIDTH  operand B, captured on accepted start
//   cin     in   1      carry-in, captured on accepted start
//   busy    out  1      high while an addition is in progress (state RUN)
//   done    out  1      one-cycle pulse: sum/cout valid
//   sum     out  WIDTH  result; held stable from done until next accepted start
//   cout    out  1      final carry-out; same hold rule as sum
// BEHAVIOUR
//   - Clocking: one clock, clk. Reset: synchronous, active-low, rst_n. Sampled on
//     rising clk only; rst_n low on an edge overrides all other inputs.
//   - Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; bit counter,
//     operand shift regs and carry flop all 0.
//   - FSM states: IDLE, RUN, DONE.
//       IDLE: start=1 -> RUN. Capture a, b; carry flop <= cin; count <= 0; sum <= 0.
//       RUN: each cycle, feed a_sh[0], b_sh[0], carry to full_adder.
//         a_sh, b_sh shift right. Sum bit enters sum reg at MSB (shift right).
//         Carry flop <= full_adder cout. count <= count+1.
//         When count==WIDTH-1 -> DONE; cout <= full_adder cout of this final bit.
//       DONE: done=1 for exactly this cycle. start=1 -> RUN with capture as in
//         IDLE (back-to-back). Otherwise -> IDLE.
//   - busy = (state==RUN); done = (state==DONE); both derived from registered state.
//   - Latency: start accepted on edge k -> busy high cycles k+1..k+WIDTH,
//     done high in cycle k+WIDTH+1. Throughput: one add per WIDTH+1 cycles.
//   - Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
//   - Boundaries:
//       start while busy: ignored; operands not re-captured; current add unaffected.
//       a/b/cin change while busy: no effect (captured copies used).
//       rst_n low mid-RUN: add aborted, all regs to reset values, no done pulse.
//       start held high continuously: adds repeat back-to-back via DONE->RUN,
//         each with operands sampled at that accept edge.
//       Counter width is $clog2(WIDTH); compare uses WIDTH-1, no wrap past it.
// STRUCTURE
//   - Shared package/include: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
//     counter-width helper.
//   - One sub-module: the existing full_adder cell, instantiated once (u_fa).
//     Port order: (sum, cout, a, b, cin).
//   - Everything else in this file: FSM, counter, operand and sum shift
//     registers, carry flop.
// TESTING  (WIDTH=8)
//   1. rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, sum=8'h00, cout=0;
//      no start accepted.
//   2. a=8'h05, b=8'h03, cin=0, start 1 cycle -> busy 8 cycles, done pulse in
//      cycle 9, sum=8'h08, cout=0.
//   3. a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1. Carry ripples through all
//      8 serial steps.
//   4. Start a=8'h10,b=8'h20; mid-RUN pulse start with a=8'hAA,b=8'h55 and toggle
//      inputs -> done once, sum=8'h30, cout=0.
//   5. start held high with a=8'h80,b=8'h80,cin=0 -> done every 9 cycles, each
//      sum=8'h00, cout=1.
//   6. rst_n low at 4th RUN cycle -> next cycle busy=0, sum=8'h00; no done.
//      Fresh start then gives a correct result.
//   Bench: self-checking against a+b+cin; $dumpfile/$dumpvars waveform;
//   $monitor of busy/done/sum.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl_pkg
// Purpose  : Shared definitions for the bit-serial add sequencer: FSM state
//            encodings and the bit-counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Bit counter width: enough bits to index 0..width-1, never below 1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage : serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Single-bit full adder cell, the shared datapath of the serial
//            adder.
// Ports    : sum  - out, a ^ b ^ cin
//            cout - out, majority(a, b, cin)
//            a    - in, operand bit A
//            b    - in, operand bit B
//            cin  - in, carry in
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial add sequencer. One full_adder cell is time-shared
//            across all WIDTH bits, LSB first, one bit per clock, with the
//            carry held in a flop. Result {cout,sum} = a + b + cin.
// Ports    : clk   - in,  rising-edge clock
//            rst_n - in,  synchronous active-low reset
//            start - in,  add request, sampled only when not busy
//            a, b  - in,  WIDTH-bit operands, captured on accepted start
//            cin   - in,  carry-in, captured on accepted start
//            busy  - out, high while an addition is in progress
//            done  - out, one-cycle pulse when sum/cout are valid
//            sum   - out, WIDTH-bit result, held until next accepted start
//            cout  - out, final carry-out, same hold rule as sum
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;

    // The single shared adder cell always looks at the LSBs of the shift
    // registers and the running carry.
    full_adder u_fa (
        .sum  (w_fa_sum),
        .cout (w_fa_cout),
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry)
    );

    // A start is only honoured outside RUN; DONE accepts for back-to-back adds.
    assign w_accept = start && (r_state == c_st_idle || r_state == c_st_done);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_accept) begin
                        r_state <= c_st_run;
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    // New sum bit enters at the MSB; after WIDTH shifts the
                    // first (LSB) result bit has arrived at bit 0.
                    r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    if (r_cnt == c_last) begin
                        r_state <= c_st_done;
                        r_cout  <= w_fa_cout;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy = (r_state == c_st_run);
    assign done = (r_state == c_st_done);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : serial_adder_ctrl
`default_nettype wire
